sram_word_ctrl: RTL and testbench
=================================

// Module: sram_word_ctrl
// PURPOSE
//   Downstream of the load/store unit: turns one 32-bit data-memory request (read or write)
//   into two 16-bit accesses on the external 256Kx16 async SRAM (low half, then high half).
//   Completion is returned as a one-cycle o_ack, which the LSU and pipeline use to release their stall.
//   Byte lanes are controlled by i_bmask; o_rdata always returns the full 32-bit word.
// PARAMETERS
//   PHASE_CYCLES  1   clocks the SRAM is driven per half-word access (>=1); sets read/write pulse width
// PORTS
//   i_clk         in   1   clock
//   i_rst_n       in   1   reset, asynchronous, active-low
//   i_addr        in   18  byte address; bits [17:2] select the word, [1:0] ignored
//   i_wdata       in   32  write data; [15:0] -> low half, [31:16] -> high half
//   i_bmask       in   4   byte enables, bit n = byte n of the word
//   i_wren        in   1   write request (level, held until o_ack)
//   i_rden        in   1   read request (level, held until o_ack)
//   o_rdata       out  32  read data, valid in the o_ack cycle and held until the next read completes
//   o_ack         out  1   one-cycle completion pulse
//   o_busy        out  1   high whenever state != IDLE
//   o_sram_addr   out  18  SRAM half-word address
//   io_sram_dq    inout 16 SRAM data bus; driven only during write phases, Z otherwise
//   o_sram_ce_n/o_sram_oe_n/o_sram_we_n/o_sram_lb_n/o_sram_ub_n  out 1 each  SRAM strobes, active-low
// BEHAVIOUR
//   - Reset (async, any state): IDLE; o_ack=0, o_busy=0, o_rdata=0, o_sram_addr=0;
//     all *_n strobes=1; dq=Z. A transaction in flight is aborted; there is no ack.
//   - All SRAM outputs are registered. States: IDLE, RD_LO, RD_HI, WR_LO, WR_GAP0, WR_HI, WR_GAP1, DONE.
//   - IDLE: on a clock edge with i_wren|i_rden, latch addr, wdata, bmask and direction.
//     If both are high, write wins. Go to WR_LO or RD_LO.
//   - Half-word address: lo = {i_addr[17:2],1'b0}, hi = {i_addr[17:2],1'b1}.
//   - RD_LO / RD_HI:
//       - Stay PHASE_CYCLES cycles with ce_n=0, oe_n=0, lb_n=ub_n=0.
//       - dq is sampled at the edge that ends the phase, into rdata[15:0] or rdata[31:16].
//       - RD_LO -> RD_HI -> DONE.
//   - WR_LO / WR_HI:
//       - Stay PHASE_CYCLES cycles with ce_n=0, oe_n=1, dq driven with the latched half.
//       - lb_n/ub_n = ~bmask of that half.
//       - we_n=0 only if that half's mask is non-zero; otherwise we_n stays 1, but the phase
//         still takes its full time.
//   - WR_GAP0 / WR_GAP1:
//       - One cycle each, we_n=1, with addr, dq and byte strobes held (hold time).
//       - Sequence: WR_LO -> WR_GAP0 -> WR_HI -> WR_GAP1 -> DONE.
//   - DONE: one cycle, o_ack=1, ce_n=1, dq=Z, requests ignored; -> IDLE.
//     o_rdata updates only at the end of a read.
//   - Latency from the accept edge to the o_ack cycle:
//       - read = 2*PHASE_CYCLES+1 cycles
//       - write = 2*PHASE_CYCLES+3 cycles
//       - back-to-back throughput: one extra IDLE cycle per transaction.
//   - Phase counter: log2(PHASE_CYCLES)+1 bits; reloads on every state change; no wrap inside a phase.
//   - An all-zero i_bmask write still completes and acks, with no we_n pulse.
//   - Request inputs changing mid-transaction have no effect (latched copy is used).
// TESTING
//   - Reset mid-write:
//       - stimulus: assert i_rst_n=0 during WR_HI
//       - response: we_n/ce_n go to 1 and dq goes Z in the same cycle; no o_ack; IDLE after release.
//   - Word write then read back (PHASE_CYCLES=1):
//       - stimulus: write 0xDEADBEEF to addr 0x00104 with bmask=1111
//       - response: SRAM[0x82]=0xBEEF, SRAM[0x83]=0xDEAD; ack 5 cycles after accept
//       - then read: o_rdata=0xDEADBEEF with ack 3 cycles after accept.
//   - Byte mask:
//       - stimulus: SRAM[0x82]=0x1234, SRAM[0x83]=0x5678, then write 0xAABBCCDD with bmask=0100
//       - response: only ub_n=1, lb_n=0 in WR_HI; read returns 0x56BB1234.
//   - Simultaneous request:
//       - stimulus: i_wren=i_rden=1
//       - response: write performed, oe_n stays 1 throughout, o_rdata unchanged.
//   - Timing and handshake (PHASE_CYCLES=3):
//       - each phase holds its strobes exactly 3 cycles; read ack at cycle 7
//       - request held through DONE: exactly one ack per transaction; a second transaction starts
//         from IDLE on the following edge.
//   - Empty mask and bus hygiene:
//       - bmask=0000 write -> we_n never 0, o_ack still pulses
//       - dq is never driven while oe_n=0 (assertion).

Source files
------------

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: splits 32-bit word requests into two 16-bit async SRAM accesses
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_addr/i_wdata/i_bmask   byte address, write data, byte enables (latched on accept)
//   i_wren/i_rden            level requests held until o_ack; write wins if both
//   o_rdata/o_ack/o_busy     read word, one-cycle completion pulse, not-idle flag
//   o_sram_*/io_sram_dq      registered SRAM address, active-low strobes, 16-bit data bus
module sram_word_ctrl #(
   parameter int PHASE_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [17:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_bmask,
   input  logic        i_wren,
   input  logic        i_rden,
   output logic [31:0] o_rdata,
   output logic        o_ack,
   output logic        o_busy,
   output logic [17:0] o_sram_addr,
   inout  wire  [15:0] io_sram_dq,
   output logic        o_sram_ce_n,
   output logic        o_sram_oe_n,
   output logic        o_sram_we_n,
   output logic        o_sram_lb_n,
   output logic        o_sram_ub_n
);
   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_GAP0, WR_HI, WR_GAP1, DONE} state_t;
   localparam int CW = $clog2(PHASE_CYCLES) + 1;
   state_t state, nstate;
   logic [CW-1:0] cnt;
   logic [15:0] word_q, lo_q, dq_out;
   logic [31:0] wdata_q;
   logic [3:0]  bmask_q;
   logic        dq_oe, phase_end, accept;
   logic [15:0] n_word;
   logic [31:0] n_wdata;
   logic [3:0]  n_bmask;
   logic [1:0]  half_bm;
   logic        lo_ph, hi_ph, rd_ph, wr_ph;
   logic        n_ce_n, n_oe_n, n_we_n, n_lb_n, n_ub_n;
   logic [17:0] n_addr;
   logic [15:0] n_dq;
   logic        unused_ok;
   assign unused_ok = ^i_addr[1:0];
   assign io_sram_dq = dq_oe ? dq_out : 16'hzzzz;
   assign o_busy = state != IDLE;
   assign phase_end = cnt == CW'(PHASE_CYCLES - 1);
   assign accept = state == IDLE && (i_wren || i_rden);
   // Outputs are registered, so they are decoded from the state being entered;
   // on the accept edge the request inputs stand in for the not-yet-latched copy.
   assign n_word  = accept ? i_addr[17:2] : word_q;
   assign n_wdata = accept ? i_wdata : wdata_q;
   assign n_bmask = accept ? i_bmask : bmask_q;
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    nstate = i_wren ? WR_LO : i_rden ? RD_LO : IDLE;
         RD_LO:   nstate = phase_end ? RD_HI : RD_LO;
         RD_HI:   nstate = phase_end ? DONE : RD_HI;
         WR_LO:   nstate = phase_end ? WR_GAP0 : WR_LO;
         WR_GAP0: nstate = WR_HI;
         WR_HI:   nstate = phase_end ? WR_GAP1 : WR_HI;
         WR_GAP1: nstate = DONE;
         default: nstate = IDLE;
      endcase
   end
   always_comb begin
      lo_ph   = nstate == RD_LO || nstate == WR_LO || nstate == WR_GAP0;
      hi_ph   = nstate == RD_HI || nstate == WR_HI || nstate == WR_GAP1;
      rd_ph   = nstate == RD_LO || nstate == RD_HI;
      wr_ph   = (lo_ph || hi_ph) && !rd_ph;
      half_bm = hi_ph ? n_bmask[3:2] : n_bmask[1:0];
      n_ce_n  = !(lo_ph || hi_ph);
      n_oe_n  = !rd_ph;
      // an empty half-mask still spends the phase, just without a write pulse
      n_we_n  = !((nstate == WR_LO || nstate == WR_HI) && |half_bm);
      n_lb_n  = rd_ph ? 1'b0 : wr_ph ? ~half_bm[0] : 1'b1;
      n_ub_n  = rd_ph ? 1'b0 : wr_ph ? ~half_bm[1] : 1'b1;
      n_addr  = lo_ph ? {n_word, 1'b0} : hi_ph ? {n_word, 1'b1} : o_sram_addr;
      n_dq    = hi_ph ? n_wdata[31:16] : n_wdata[15:0];
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= nstate;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt         <= '0;
         word_q      <= '0;
         wdata_q     <= '0;
         bmask_q     <= '0;
         lo_q        <= '0;
         o_rdata     <= '0;
         o_ack       <= 1'b0;
         o_sram_addr <= '0;
         o_sram_ce_n <= 1'b1;
         o_sram_oe_n <= 1'b1;
         o_sram_we_n <= 1'b1;
         o_sram_lb_n <= 1'b1;
         o_sram_ub_n <= 1'b1;
         dq_oe       <= 1'b0;
         dq_out      <= '0;
      end else begin
         cnt         <= (nstate != state || state == IDLE) ? '0 : cnt + 1'b1;
         word_q      <= n_word;
         wdata_q     <= n_wdata;
         bmask_q     <= n_bmask;
         if (state == RD_LO && phase_end) lo_q <= io_sram_dq;
         if (state == RD_HI && phase_end) o_rdata <= {io_sram_dq, lo_q};
         o_ack       <= nstate == DONE;
         o_sram_addr <= n_addr;
         o_sram_ce_n <= n_ce_n;
         o_sram_oe_n <= n_oe_n;
         o_sram_we_n <= n_we_n;
         o_sram_lb_n <= n_lb_n;
         o_sram_ub_n <= n_ub_n;
         dq_oe       <= wr_ph;
         dq_out      <= n_dq;
      end
   end
endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb_sram_word_ctrl: directed table-driven bench for sram_word_ctrl (PHASE_CYCLES 1 and 3)
module tb_sram_word_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [17:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  bmask = '0;
   logic wren = 1'b0, rden = 1'b0, wren3 = 1'b0, rden3 = 1'b0;
   logic [31:0] rdata, rdata3;
   logic ack, busy, ce_n, oe_n, we_n, lb_n, ub_n;
   logic ack3, busy3, ce3_n, oe3_n, we3_n, lb3_n, ub3_n;
   logic [17:0] sram_addr, sram_addr3;
   wire  [15:0] dq, dq3;
   logic [15:0] mem [0:1023];
   int errors = 0, checks = 0, we_cnt = 0, oe_cnt = 0, we3_cnt = 0, oe3_cnt = 0, viol = 0;
   logic [1:0] last_strb = 2'b11;

   always #5 clk = ~clk;

   sram_word_ctrl #(.PHASE_CYCLES(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
      .i_wren(wren), .i_rden(rden), .o_rdata(rdata), .o_ack(ack), .o_busy(busy),
      .o_sram_addr(sram_addr), .io_sram_dq(dq), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
      .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n));

   sram_word_ctrl #(.PHASE_CYCLES(3)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
      .i_wren(wren3), .i_rden(rden3), .o_rdata(rdata3), .o_ack(ack3), .o_busy(busy3),
      .o_sram_addr(sram_addr3), .io_sram_dq(dq3), .o_sram_ce_n(ce3_n), .o_sram_oe_n(oe3_n),
      .o_sram_we_n(we3_n), .o_sram_lb_n(lb3_n), .o_sram_ub_n(ub3_n));

   // SRAM models: a real array for the fast instance, an address-derived pattern for the slow one
   assign dq  = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'hzzzz;
   assign dq3 = (!ce3_n && !oe3_n) ? (sram_addr3[15:0] ^ 16'hA5A5) : 16'hzzzz;

   always @(negedge clk) begin
      if (!we_n) begin
         we_cnt++;
         last_strb = {lb_n, ub_n};
      end
      if (!oe_n) oe_cnt++;
      if (!we3_n) we3_cnt++;
      if (!oe3_n) oe3_cnt++;
      if (!oe_n && dut.dq_oe) viol++;
      if (!oe3_n && dut3.dq_oe) viol++;
      if (!ce_n && !we_n && !lb_n) mem[sram_addr[9:0]][7:0] = dq[7:0];
      if (!ce_n && !we_n && !ub_n) mem[sram_addr[9:0]][15:8] = dq[15:8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run(input bit sel, input bit wr, input bit rd, input logic [17:0] a,
                      input logic [31:0] wd, input logic [3:0] bm,
                      output int lat, output logic [31:0] rdat);
      we_cnt = 0; oe_cnt = 0; we3_cnt = 0; oe3_cnt = 0;
      @(negedge clk);
      addr = a; wdata = wd; bmask = bm;
      if (sel) begin wren3 = wr; rden3 = rd; end
      else     begin wren = wr;  rden = rd;  end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(sel ? ack3 : ack) && lat < 60);
      rdat = sel ? rdata3 : rdata;
      wren = 0; rden = 0; wren3 = 0; rden3 = 0;
      @(negedge clk);
      chk("ack_one_cycle", {31'b0, sel ? ack3 : ack}, 0);
      chk("idle_after_done", {31'b0, sel ? busy3 : busy}, 0);
   endtask

   typedef struct {
      bit wr, rd;
      logic [17:0] a;
      logic [31:0] wd;
      logic [3:0] bm;
      int lat, we, oe;
      logic [1:0] strb;
      logic [31:0] rexp;
   } vec_t;
   vec_t tbl [9];

   initial begin
      int lat, n;
      logic [31:0] r;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      tbl[0] = '{1, 0, 18'h00104, 32'hDEADBEEF, 4'hF, 5, 2, 0, 2'b00, 32'h0};
      tbl[1] = '{0, 1, 18'h00104, 32'h0,        4'hF, 3, 0, 2, 2'b00, 32'hDEADBEEF};
      tbl[2] = '{1, 0, 18'h00104, 32'h56781234, 4'hF, 5, 2, 0, 2'b00, 32'hDEADBEEF};
      tbl[3] = '{1, 0, 18'h00104, 32'hAABBCCDD, 4'h4, 5, 1, 0, 2'b01, 32'hDEADBEEF};
      tbl[4] = '{0, 1, 18'h00104, 32'h0,        4'h0, 3, 0, 2, 2'b00, 32'h56BB1234};
      tbl[5] = '{1, 1, 18'h0010B, 32'h0BADF00D, 4'h3, 5, 1, 0, 2'b00, 32'h56BB1234};
      tbl[6] = '{1, 0, 18'h00108, 32'h12345678, 4'h0, 5, 0, 0, 2'b00, 32'h56BB1234};
      tbl[7] = '{0, 1, 18'h0010A, 32'h0,        4'hF, 3, 0, 2, 2'b00, 32'h0000F00D};
      tbl[8] = '{0, 1, 18'h00000, 32'h0,        4'hF, 3, 0, 2, 2'b00, 32'h00000000};

      repeat (2) @(negedge clk);
      chk("rst_ack", {31'b0, ack}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_sram_addr", {14'b0, sram_addr}, 0);
      chk("rst_strobes", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
      chk("rst_dq_z", {31'b0, dq === 16'hzzzz}, 1);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run(0, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].bm, lat, r);
         chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
         chk($sformatf("v%0d_rdata", i), r, tbl[i].rexp);
         chk($sformatf("v%0d_we_cycles", i), we_cnt, tbl[i].we);
         chk($sformatf("v%0d_oe_cycles", i), oe_cnt, tbl[i].oe);
         if (tbl[i].we != 0) chk($sformatf("v%0d_lb_ub", i), {30'b0, last_strb}, {30'b0, tbl[i].strb});
      end
      chk("mem_82", {16'b0, mem[10'h082]}, 32'h1234);
      chk("mem_83", {16'b0, mem[10'h083]}, 32'h56BB);
      chk("mem_84", {16'b0, mem[10'h084]}, 32'hF00D);
      chk("mem_85", {16'b0, mem[10'h085]}, 32'h0000);

      run(1, 0, 1, 18'h00104, 32'h0, 4'hF, lat, r);
      chk("p3_read_latency", lat, 7);
      chk("p3_read_oe_cycles", oe3_cnt, 6);
      chk("p3_read_rdata", r, {16'h0083 ^ 16'hA5A5, 16'h0082 ^ 16'hA5A5});
      run(1, 1, 0, 18'h00200, 32'h13572468, 4'hF, lat, r);
      chk("p3_write_latency", lat, 9);
      chk("p3_write_we_cycles", we3_cnt, 6);

      @(negedge clk);
      addr = 18'h00104; rden3 = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!ack3 && lat < 60);
      chk("b2b_first_latency", lat, 7);
      n = 0;
      do begin @(negedge clk); n++; end while (!ack3 && n < 60);
      chk("b2b_next_ack_gap", n, 8);
      rden3 = 1'b0;
      @(negedge clk);
      chk("b2b_ack_one_cycle", {31'b0, ack3}, 0);
      repeat (12) @(negedge clk);

      addr = 18'h00200; wdata = 32'hCAFEF00D; bmask = 4'hF; wren = 1'b1;
      repeat (3) @(negedge clk);
      chk("midwr_in_wr_hi", {31'b0, we_n}, 0);
      rst_n = 1'b0;
      #1;
      chk("midwr_we_n", {31'b0, we_n}, 1);
      chk("midwr_ce_n", {31'b0, ce_n}, 1);
      chk("midwr_dq_z", {31'b0, dq === 16'hzzzz}, 1);
      chk("midwr_busy", {31'b0, busy}, 0);
      chk("midwr_rdata_cleared", rdata, 0);
      @(negedge clk);
      wren = 1'b0; rst_n = 1'b1;
      n = 0;
      repeat (6) begin @(negedge clk); n += int'(ack); end
      chk("midwr_no_ack", n, 0);
      chk("midwr_idle", {31'b0, busy}, 0);

      chk("bus_hygiene", viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
